// File: rtl/mem_access_stage_if.sv
// Bus bundle of the memory-access pipeline stage: the pipeline drives the master side and the stage is the slave.
// The write-back sideband fields and the PC ride through the stage unchanged.
interface mem_access_stage_if #(
   parameter int NB_DATA = 32
);
   logic               en_pipeline;
   logic [NB_DATA-1:0] alu_result_i;
   logic [NB_DATA-1:0] data_wr_to_mem_i;
   logic [5:0]         mem_signals_i;
   logic [2:0]         wb_signals_i;
   logic [4:0]         writeReg_i;
   logic [6:0]         pc_i;

   logic [NB_DATA-1:0] alu_result_o;
   logic [NB_DATA-1:0] read_data_o;
   logic [2:0]         wb_signals_o;
   logic [4:0]         writeReg_o;
   logic [6:0]         pc_o;
   logic               busy_o;
   logic               misaligned_o;

   modport master (
      output en_pipeline, alu_result_i, data_wr_to_mem_i, mem_signals_i,
             wb_signals_i, writeReg_i, pc_i,
      input  alu_result_o, read_data_o, wb_signals_o, writeReg_o, pc_o,
             busy_o, misaligned_o
   );

   modport slave (
      input  en_pipeline, alu_result_i, data_wr_to_mem_i, mem_signals_i,
             wb_signals_i, writeReg_i, pc_i,
      output alu_result_o, read_data_o, wb_signals_o, writeReg_o, pc_o,
             busy_o, misaligned_o
   );
endinterface

// File: rtl/mem_access_stage.sv
// Data-memory stage: byte/half/word loads are combinational and stores commit at the clock edge; after reset the memory is zeroed (busy_o high for 2^NB_ADDR cycles).
// No backpressure; misaligned accesses are dropped and flagged stickily. MEM_ACCESS_DEBUG_PORT_EN adds a raw word read port.
module mem_access_stage #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5
) (
   input logic                clock,
   input logic                reset,
   mem_access_stage_if.slave  bus
`ifdef MEM_ACCESS_DEBUG_PORT_EN
   ,
   input  logic [NB_ADDR-1:0] debug_addr_i,
   output logic [NB_DATA-1:0] debug_data_o
`endif
);

   localparam int DEPTH = 1 << NB_ADDR;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NB_ADDR-1:0] cnt_q, cnt_d;
   logic               misaligned_q, misaligned_d;
   logic [NB_DATA-1:0] mem_q [DEPTH];

   logic               mem_read, mem_write, ld_unsigned;
   logic [1:0]         size, offset;
   logic               is_half, is_word, access_misaligned;
   logic [NB_ADDR-1:0] word_idx;
   logic [NB_DATA-1:0] rd_word, merged_word, load_data;
   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;

   logic               mem_we;
   logic [NB_ADDR-1:0] mem_waddr;
   logic [NB_DATA-1:0] mem_wdata;
   logic [NB_DATA-1:0] read_data;
   logic               unused_mem_sig;

   assign mem_read       = bus.mem_signals_i[0];
   assign mem_write      = bus.mem_signals_i[1];
   assign size           = bus.mem_signals_i[3:2];
   assign ld_unsigned    = bus.mem_signals_i[4];
   assign unused_mem_sig = bus.mem_signals_i[5];

   // Address bits above the word index are dropped, so accesses wrap modulo the memory size.
   assign word_idx = bus.alu_result_i[NB_ADDR+1:2];
   assign offset   = bus.alu_result_i[1:0];

   assign is_half           = (size == 2'b01);
   assign is_word           = size[1];
   assign access_misaligned = (is_half & offset[0]) | (is_word & (offset != 2'b00));

   assign rd_word = mem_q[word_idx];
   assign ld_byte = rd_word[{offset, 3'b000} +: 8];
   assign ld_half = rd_word[{offset[1], 4'b0000} +: 16];

   always_comb begin
      merged_word = rd_word;
      if (is_word) begin
         merged_word = bus.data_wr_to_mem_i;
      end else if (is_half) begin
         merged_word[{offset[1], 4'b0000} +: 16] = bus.data_wr_to_mem_i[15:0];
      end else begin
         merged_word[{offset, 3'b000} +: 8] = bus.data_wr_to_mem_i[7:0];
      end
   end

   always_comb begin
      load_data = '0;
      if (is_word) begin
         load_data = rd_word;
      end else if (is_half) begin
         load_data = {{(NB_DATA-16){~ld_unsigned & ld_half[15]}}, ld_half};
      end else begin
         load_data = {{(NB_DATA-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      misaligned_d = misaligned_q;
      mem_we       = 1'b0;
      mem_waddr    = word_idx;
      mem_wdata    = merged_word;
      read_data    = '0;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == {NB_ADDR{1'b1}}) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mem_read && !access_misaligned) begin
               read_data = load_data;
            end
            if ((mem_read || mem_write) && access_misaligned) begin
               misaligned_d = 1'b1;
            end
            mem_we = bus.en_pipeline & mem_write & ~access_misaligned;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         cnt_q        <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Storage is not reset directly; the CLEAR sweep zeroes it, and reset edges never write.
   always_ff @(posedge clock) begin
      if (!reset && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.alu_result_o = bus.alu_result_i;
   assign bus.wb_signals_o = bus.wb_signals_i;
   assign bus.writeReg_o   = bus.writeReg_i;
   assign bus.pc_o         = bus.pc_i;
   assign bus.read_data_o  = read_data;
   assign bus.busy_o       = (state_q == ST_CLEAR);
   assign bus.misaligned_o = misaligned_q;

`ifdef MEM_ACCESS_DEBUG_PORT_EN
   assign debug_data_o = mem_q[debug_addr_i];
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-mask memory model, plus directed reset/clear/alignment cases.
module tb_mem_access_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_stage_if #(.NB_DATA(32)) bus ();

`ifdef MEM_ACCESS_DEBUG_PORT_EN
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data;
`endif

   mem_access_stage #(.NB_DATA(32), .NB_ADDR(5)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
`ifdef MEM_ACCESS_DEBUG_PORT_EN
      ,
      .debug_addr_i (dbg_addr),
      .debug_data_o (dbg_data)
`endif
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_mem [32];
   bit          model_mis;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
      int off = int'(addr % 4);
      if (size == 2'd1) return (off % 2) != 0;
      if (size >= 2'd2) return off != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input bit rd, input logic [1:0] size,
                                              input bit uns, input logic [31:0] addr);
      int          idx  = int'((addr / 4) % 32);
      int          off  = int'(addr % 4);
      logic [31:0] word = model_mem[idx];
      logic [31:0] v;
      if (!rd || is_mis(size, addr)) return 32'd0;
      if (size == 2'd0) begin
         v = (word >> (8 * off)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = (word >> (8 * off)) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] data);
      int          idx = int'((addr / 4) % 32);
      int          off = int'(addr % 4);
      logic [31:0] mask;
      if (size == 2'd0)      mask = 32'hFF << (8 * off);
      else if (size == 2'd1) mask = 32'hFFFF << (8 * off);
      else                   mask = 32'hFFFF_FFFF;
      model_mem[idx] = (model_mem[idx] & ~mask) | ((data << (8 * off)) & mask);
   endfunction

   task automatic drive_idle();
      bus.en_pipeline      = 1'b1;
      bus.alu_result_i     = '0;
      bus.data_wr_to_mem_i = '0;
      bus.mem_signals_i    = '0;
      bus.wb_signals_i     = '0;
      bus.writeReg_i       = '0;
      bus.pc_i             = '0;
   endtask

   // Entered just after a rising edge; returns just after the next one.
   task automatic access(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data, input bit en,
                         input string tag, output logic [31:0] rd_val);
      logic [2:0] wb     = 3'($urandom);
      logic [4:0] wreg   = 5'($urandom);
      logic [6:0] pc     = 7'($urandom);
      bus.en_pipeline      = en;
      bus.alu_result_i     = addr;
      bus.data_wr_to_mem_i = data;
      bus.mem_signals_i    = {1'($urandom), uns, size, wr, rd};
      bus.wb_signals_i     = wb;
      bus.writeReg_i       = wreg;
      bus.pc_i             = pc;
      @(negedge clk);
      rd_val = bus.read_data_o;
      check_eq({tag, ":rd"}, rd_val, model_load(rd, size, uns, addr));
      check_eq({tag, ":alu"}, bus.alu_result_o, addr);
      check_eq({tag, ":pass"}, {17'd0, bus.wb_signals_o, bus.writeReg_o, bus.pc_o},
               {17'd0, wb, wreg, pc});
      check_eq({tag, ":busy"}, {31'd0, bus.busy_o}, 32'd0);
      @(posedge clk);
      if ((rd || wr) && is_mis(size, addr)) model_mis = 1'b1;
      if (wr && en && !is_mis(size, addr)) model_store(size, addr, data);
      #1;
      check_eq({tag, ":mis"}, {31'd0, bus.misaligned_o}, {31'd0, model_mis});
   endtask

   // Counts edges until busy_o drops while hammering stores at word 0.
   task automatic wait_clear(input string tag);
      int n = 0;
      bus.en_pipeline      = 1'b1;
      bus.alu_result_i     = 32'h0;
      bus.data_wr_to_mem_i = 32'hFFFF_FFFF;
      bus.mem_signals_i    = 6'b001011;
      #1;
      check_eq({tag, ":clr_rd"}, bus.read_data_o, 32'd0);
      while (bus.busy_o === 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq({tag, ":clr_len"}, n, 32);
      drive_idle();
   endtask

   task automatic do_reset(input string tag);
      rst                  = 1'b1;
      bus.en_pipeline      = 1'b1;
      bus.alu_result_i     = 32'h0;
      bus.data_wr_to_mem_i = 32'hA5A5_A5A5;
      bus.mem_signals_i    = 6'b001010;
      @(posedge clk);
      #1;
      check_eq({tag, ":busy_rst"}, {31'd0, bus.busy_o}, 32'd1);
      check_eq({tag, ":mis_rst"}, {31'd0, bus.misaligned_o}, 32'd0);
      rst       = 1'b0;
      model_mis = 1'b0;
      for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
      wait_clear(tag);
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] addr;
      logic [1:0]  size;
      rst = 1'b1;
      drive_idle();
      do_reset("rst0");

      for (int i = 0; i < 4; i++) begin
         access(1, 0, 2'd2, 0, 32'($urandom_range(0, 31)) << 2, 0, 1, "zero_lw", v);
         check_eq("zero_lw_lit", v, 32'd0);
      end
      access(1, 0, 2'd2, 0, 32'h0, 0, 1, "w0_after_clear", v);

      access(0, 1, 2'd2, 0, 32'h08, 32'h8000_00F1, 1, "sw08", v);
      access(1, 0, 2'd0, 0, 32'h08, 0, 1, "lb08", v);
      check_eq("lb08_lit", v, 32'hFFFF_FFF1);
      access(1, 0, 2'd0, 1, 32'h08, 0, 1, "lbu08", v);
      check_eq("lbu08_lit", v, 32'h0000_00F1);
      access(1, 0, 2'd2, 0, 32'h08, 0, 1, "lw08", v);
      check_eq("lw08_lit", v, 32'h8000_00F1);

      access(0, 1, 2'd1, 0, 32'h0E, 32'h0000_BEEF, 1, "sh0e", v);
      access(1, 0, 2'd2, 0, 32'h0C, 0, 1, "lw0c", v);
      check_eq("lw0c_lit", v, 32'hBEEF_0000);
      access(1, 0, 2'd1, 0, 32'h0E, 0, 1, "lh0e", v);
      check_eq("lh0e_lit", v, 32'hFFFF_BEEF);

      access(0, 1, 2'd2, 0, 32'h05, 32'hDEAD_BEEF, 1, "sw05", v);
      check_eq("mis_lit", {31'd0, bus.misaligned_o}, 32'd1);
      access(1, 0, 2'd2, 0, 32'h04, 0, 1, "lw04", v);
      check_eq("lw04_lit", v, 32'd0);
      access(1, 0, 2'd2, 0, 32'h00, 0, 1, "mis_sticky", v);
      check_eq("mis_sticky_lit", {31'd0, bus.misaligned_o}, 32'd1);

      access(0, 1, 2'd2, 0, 32'h10, 32'h1234_5678, 0, "sw10_noen", v);
      access(1, 0, 2'd2, 0, 32'h10, 0, 1, "lw10", v);
      check_eq("lw10_lit", v, 32'd0);
      access(0, 1, 2'd2, 0, 32'h90, 32'hCAFE_F00D, 1, "sw90", v);
      access(1, 0, 2'd2, 0, 32'h10, 0, 1, "lw10_wrap", v);
      check_eq("lw10_wrap_lit", v, 32'hCAFE_F00D);
      access(1, 1, 2'd2, 0, 32'h10, 32'h0BAD_CAFE, 1, "rmw10", v);
      check_eq("rmw10_lit", v, 32'hCAFE_F00D);

      // Reset during RUN must wipe memory and the sticky flag.
      do_reset("rst_run");
      access(1, 0, 2'd2, 0, 32'h10, 0, 1, "lw10_after_rst", v);
      check_eq("lw10_after_rst_lit", v, 32'd0);

      // Reset at clear cycle 10 restarts a full sweep.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("midclr_busy", {31'd0, bus.busy_o}, 32'd1);
      do_reset("rst_midclr");

      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset("rst_rand");
         size = 2'($urandom);
         addr = $urandom;
         if ($urandom_range(0, 7) != 0) begin
            if (size == 2'd1) addr[0] = 1'b0;
            if (size >= 2'd2) addr[1:0] = 2'b00;
         end
         access(1'($urandom), 1'($urandom), size, 1'($urandom), addr, $urandom,
                $urandom_range(0, 3) != 0, "rand", v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, data and address width.
REQ-002 The module SHALL have parameter NB_ADDR, default 5, word-index width (memory depth 2^NB_ADDR words).
REQ-003 The module SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port en_pipeline, input, 1, store enable; 0 freezes the memory contents.
REQ-006 The module SHALL have port alu_result_i, input, NB_DATA, byte address (word index = bits [NB_ADDR+1:2], offset = bits [1:0]).
REQ-007 The module SHALL have port data_wr_to_mem_i, input, NB_DATA, store data, right-aligned.
REQ-008 The module SHALL have port mem_signals_i, input, 6, with bit0 mem_read, bit1 mem_write, bits[3:2] size (00 byte, 01 half, 10 word, 11 treated as word), bit4 unsigned load, bit5 reserved and ignored.
REQ-009 The module SHALL have ports wb_signals_i (3), writeReg_i (5) and pc_i (7), inputs, forwarded combinationally to wb_signals_o, writeReg_o and pc_o.
REQ-010 The module SHALL have port alu_result_o, output, NB_DATA, equal to alu_result_i.
REQ-011 The module SHALL have port read_data_o, output, NB_DATA, extended load data, combinational from the current address.
REQ-012 The module SHALL have port busy_o, output, 1, high while the clear sequence runs.
REQ-013 The module SHALL have port misaligned_o, output, 1, sticky misaligned-access flag.

Function
REQ-014 The module SHALL implement a two-state FSM, CLEAR and RUN, with a NB_ADDR-bit clear counter.
REQ-015 In CLEAR the module SHALL write 0 to the word at the counter each cycle and increment the counter; at count 2^NB_ADDR-1 it SHALL move to RUN, so the clear takes 2^NB_ADDR cycles.
REQ-016 busy_o SHALL be 1 in CLEAR and 0 in RUN.
REQ-017 In CLEAR, read_data_o SHALL be 0 and store requests SHALL be ignored.
REQ-018 In RUN, a store SHALL occur at the clock edge when en_pipeline=1, mem_write=1 and the access is aligned.
REQ-019 Byte stores SHALL write data_wr_to_mem_i[7:0] into the byte lane selected by the offset; half stores SHALL write [15:0] into lane offset[1]; word stores SHALL write all bytes; all other lanes are unchanged.
REQ-020 In RUN with mem_read=1, read_data_o SHALL be the selected byte or half, sign-extended (bit4=0) or zero-extended (bit4=1), or the full word for word size; with mem_read=0, read_data_o SHALL be 0.
REQ-021 An access SHALL be misaligned when it is a half with offset[0]=1 or a word with offset!=0; a misaligned store SHALL be suppressed and a misaligned load SHALL return 0.
REQ-022 misaligned_o SHALL set at the edge where a misaligned access with mem_read or mem_write occurs in RUN, and SHALL clear only on reset.
REQ-023 When mem_read and mem_write are both set, read_data_o SHALL reflect the pre-write contents in that cycle.
REQ-024 alu_result_i address bits above NB_ADDR+1 SHALL be ignored, so addresses wrap modulo the memory size.

Reset
REQ-025 While reset=1 at a clock edge, the FSM SHALL enter CLEAR, the counter SHALL be 0 and misaligned_o SHALL be 0; busy_o SHALL be 1 from the first edge with reset high.
REQ-026 Reset asserted mid-CLEAR or mid-RUN SHALL restart the clear from word 0, and no store SHALL occur on a reset edge.

Configuration
REQ-027 With macro MEM_ACCESS_DEBUG_PORT_EN defined, the module SHALL add inputs debug_addr_i (NB_ADDR) and output debug_data_o (NB_DATA) giving the raw stored word combinationally.
REQ-028 With MEM_ACCESS_DEBUG_PORT_EN undefined, these ports SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-029 Release reset -> busy_o=1 for exactly 32 cycles, then 0; any word read in RUN returns 0.
REQ-030 Word store 0x8000_00F1 to address 0x08, then lb at 0x08 -> 0xFFFF_FFF1; lbu at 0x08 -> 0x0000_00F1; lw at 0x08 -> 0x8000_00F1.
REQ-031 Sh 0xBEEF at 0x0E over word 0 -> lw 0x0C returns 0xBEEF_0000; lh at 0x0E returns 0xFFFF_BEEF.
REQ-032 Sw at 0x05 -> memory unchanged, misaligned_o=1 and it stays 1 until reset.
REQ-033 Sw 0x1234_5678 to 0x10 with en_pipeline=0 -> lw 0x10 returns 0; store at address 0x90 -> lands in word 4 (wraps).
REQ-034 Reset asserted at clear cycle 10 -> busy_o stays 1 for 32 further cycles after release.
